// File: rtl/neander_core.sv
// neander_core: two-cycle fetch/execute control unit and datapath of the Neander accumulator machine
module neander_core #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              halted,
    output logic [ADDR_W-1:0] pc_o,
    output logic [DATA_W-1:0] ac_o,
    output logic              flag_n,
    output logic              flag_z
);
    typedef enum logic [1:0] {FETCH, EXEC, HALT} state_t;

    localparam logic [3:0] OP_STA = 4'h1;
    localparam logic [3:0] OP_LDA = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_NOT = 4'h6;
    localparam logic [3:0] OP_JMP = 4'h8;
    localparam logic [3:0] OP_JN  = 4'h9;
    localparam logic [3:0] OP_JZ  = 4'hA;
    localparam logic [3:0] OP_HLT = 4'hF;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ac_q, ac_d;
    // Only the opcode and operand fields are kept; the ignored middle nibble is dropped at fetch.
    logic [ADDR_W+3:0] ir_q, ir_d;
    logic [3:0]        opcode;
    logic [ADDR_W-1:0] operand;

    assign opcode  = ir_q[ADDR_W+3:ADDR_W];
    assign operand = ir_q[ADDR_W-1:0];

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            pc_q    <= '0;
            ac_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ac_q    <= ac_d;
            ir_q    <= ir_d;
        end
    end

    // Next state: fetch/execute loop, HLT parks in HALT, run low holds
    always_comb begin
        state_d = state_q;
        if (run) begin
            case (state_q)
                FETCH:   state_d = EXEC;
                EXEC:    state_d = (opcode == OP_HLT) ? HALT : FETCH;
                default: state_d = state_q;
            endcase
        end
    end

    // Datapath next values: fetch latches the instruction, execute applies the opcode
    always_comb begin
        pc_d = pc_q;
        ac_d = ac_q;
        ir_d = ir_q;
        if (run && state_q == FETCH) begin
            ir_d = {mem_rdata[DATA_W-1 -: 4], mem_rdata[ADDR_W-1:0]};
            pc_d = pc_q + ADDR_W'(1);
        end else if (run && state_q == EXEC) begin
            case (opcode)
                OP_LDA:  ac_d = mem_rdata;
                OP_ADD:  ac_d = ac_q + mem_rdata;
                OP_OR:   ac_d = ac_q | mem_rdata;
                OP_AND:  ac_d = ac_q & mem_rdata;
                OP_NOT:  ac_d = ~ac_q;
                OP_JMP:  pc_d = operand;
                OP_JN:   pc_d = ac_q[DATA_W-1] ? operand : pc_q;
                OP_JZ:   pc_d = (ac_q == '0) ? operand : pc_q;
                default: ac_d = ac_q;
            endcase
        end
    end

    // Outputs: the write strobe is gated by run so a stalled STA never writes
    always_comb begin
        mem_addr  = (state_q == EXEC) ? operand : pc_q;
        mem_write = run && state_q == EXEC && opcode == OP_STA;
        mem_wdata = ac_q;
        halted    = state_q == HALT;
        pc_o      = pc_q;
        ac_o      = ac_q;
        flag_n    = ac_q[DATA_W-1];
        flag_z    = ac_q == '0;
    end
endmodule

// File: tb/tb_neander_core.sv
// tb_neander_core: directed scenarios plus random programs checked against an instruction-level model
module tb_neander_core;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic [7:0]  mem_addr;
    logic        mem_write;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        halted;
    logic [7:0]  pc_o;
    logic [15:0] ac_o;
    logic        flag_n;
    logic        flag_z;

    logic [15:0] mem [256];
    logic [15:0] ref_mem [256];
    logic [7:0]  ref_pc;
    logic [15:0] ref_ac;
    bit          ref_halt;
    int          n_cmp = 0;
    int          n_err = 0;

    neander_core #(.ADDR_W(8), .DATA_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .mem_addr(mem_addr), .mem_write(mem_write), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .halted(halted), .pc_o(pc_o), .ac_o(ac_o), .flag_n(flag_n), .flag_z(flag_z)
    );

    always #5 clk = ~clk;

    // 256x16 RAM: combinational read, write on the rising edge
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_write) mem[mem_addr] = mem_wdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input logic r);
        run = r;
        @(posedge clk);
        @(negedge clk);
        if (!r) check("stall_no_write", mem_write, 0);
    endtask

    task automatic ticks(input int n);
        repeat (n) tick(1'b1);
    endtask

    task automatic clear_mem();
        foreach (mem[i]) mem[i] = 16'h0000;
    endtask

    task automatic do_reset();
        run = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_pc", pc_o, 0);
        check("rst_ac", ac_o, 0);
        check("rst_halted", halted, 0);
        check("rst_mem_write", mem_write, 0);
        check("rst_mem_addr", mem_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Instruction-level reference: one whole instruction per call
    task automatic ref_step();
        logic [15:0] w;
        logic [7:0]  a;
        w = ref_mem[ref_pc];
        a = w[7:0];
        ref_pc = ref_pc + 8'd1;
        case (w[15:12])
            4'h1: ref_mem[a] = ref_ac;
            4'h2: ref_ac = ref_mem[a];
            4'h3: ref_ac = ref_ac + ref_mem[a];
            4'h4: ref_ac = ref_ac | ref_mem[a];
            4'h5: ref_ac = ref_ac & ref_mem[a];
            4'h6: ref_ac = ~ref_ac;
            4'h8: ref_pc = a;
            4'h9: if (ref_ac[15]) ref_pc = a;
            4'hA: if (ref_ac == 16'h0) ref_pc = a;
            4'hF: ref_halt = 1'b1;
            default: ;
        endcase
    endtask

    initial begin
        // Basic program: LDA/ADD/STA/HLT
        clear_mem();
        mem[0] = 16'h2080; mem[1] = 16'h3081; mem[2] = 16'h1082; mem[3] = 16'hF000;
        mem[8'h80] = 16'h0005; mem[8'h81] = 16'h0007;
        do_reset();
        ticks(7);
        check("t1_not_halted_at_7", halted, 0);
        tick(1'b1);
        check("t1_halted_at_8", halted, 1);
        check("t1_ac", ac_o, 16'h000C);
        check("t1_pc", pc_o, 8'h04);
        check("t1_mem82", mem[8'h82], 16'h000C);
        ticks(3);
        check("t1_halt_frozen_pc", pc_o, 8'h04);

        // Add wraps to zero, flags, taken JZ
        clear_mem();
        mem[0] = 16'h2010; mem[1] = 16'h3011; mem[2] = 16'hA040; mem[8'h40] = 16'hF000;
        mem[8'h10] = 16'hFFFF; mem[8'h11] = 16'h0001;
        do_reset();
        ticks(2);
        check("t2_flag_n_ffff", flag_n, 1);
        ticks(2);
        check("t2_ac_wrap", ac_o, 16'h0000);
        check("t2_flag_z", flag_z, 1);
        check("t2_flag_n", flag_n, 0);
        ticks(2);
        check("t2_jz_taken_pc", pc_o, 8'h40);

        // Not-taken JN, NOT, taken JN
        clear_mem();
        mem[0] = 16'h2020; mem[5] = 16'h9040; mem[6] = 16'h6000; mem[7] = 16'h9040;
        mem[8'h20] = 16'h0001; mem[8'h40] = 16'hF000;
        do_reset();
        ticks(12);
        check("t3_jn_not_taken_pc", pc_o, 8'h06);
        ticks(2);
        check("t3_not_ac", ac_o, 16'hFFFE);
        check("t3_not_flag_n", flag_n, 1);
        ticks(2);
        check("t3_jn_taken_pc", pc_o, 8'h40);

        // PC wrap through 0xFF, with HLT planted at 0x00 by self-modifying STA
        clear_mem();
        mem[0] = 16'h2010; mem[1] = 16'h1000; mem[2] = 16'h80FF; mem[8'h10] = 16'hF000;
        do_reset();
        ticks(4);
        check("t4_selfmod_word", mem[0], 16'hF000);
        ticks(2);
        check("t4_jmp_ff", pc_o, 8'hFF);
        ticks(2);
        check("t4_pc_wrap", pc_o, 8'h00);
        check("t4_not_yet_halted", halted, 0);
        ticks(2);
        check("t4_halted", halted, 1);
        check("t4_halt_pc", pc_o, 8'h01);

        // Stall during STA execute
        clear_mem();
        mem[0] = 16'h2010; mem[1] = 16'h1030; mem[2] = 16'hF000; mem[8'h10] = 16'h1234;
        do_reset();
        ticks(3);
        repeat (3) tick(1'b0);
        check("t5_no_write_during_stall", mem[8'h30], 16'h0000);
        check("t5_addr_during_stall", mem_addr, 8'h30);
        run = 1'b1;
        #1;
        check("t5_write_on_release", mem_write, 1);
        check("t5_wdata", mem_wdata, 16'h1234);
        @(posedge clk);
        @(negedge clk);
        check("t5_single_write", mem_write, 0);
        check("t5_mem30", mem[8'h30], 16'h1234);

        // Asynchronous reset in the middle of an STA execute
        clear_mem();
        mem[0] = 16'h2010; mem[1] = 16'h1031; mem[8'h10] = 16'hBEEF;
        do_reset();
        ticks(3);
        check("t6_sta_strobe", mem_write, 1);
        rst_n = 1'b0;
        #1;
        check("t6_async_write_drop", mem_write, 0);
        check("t6_async_pc", pc_o, 8'h00);
        check("t6_async_ac", ac_o, 16'h0000);
        check("t6_async_addr", mem_addr, 8'h00);
        @(negedge clk);
        @(negedge clk);
        check("t6_mem_untouched", mem[8'h31], 16'h0000);
        rst_n = 1'b1;
        tick(1'b1);
        check("t6_restart_pc", pc_o, 8'h01);
        check("t6_restart_ac", ac_o, 16'h0000);

        // Random programs with random stalls against the instruction-level model
        for (int p = 0; p < 20; p++) begin
            int diff;
            foreach (mem[i]) mem[i] = 16'($urandom);
            foreach (mem[i]) ref_mem[i] = mem[i];
            ref_pc = 8'h00;
            ref_ac = 16'h0000;
            ref_halt = 1'b0;
            do_reset();
            for (int k = 0; k < 150 && !ref_halt; k++) begin
                check("rnd_pc", pc_o, ref_pc);
                check("rnd_ac", ac_o, ref_ac);
                check("rnd_flag_n", flag_n, ref_ac[15]);
                check("rnd_flag_z", flag_z, ref_ac == 16'h0);
                check("rnd_halted", halted, 0);
                ref_step();
                repeat (2) begin
                    if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick(1'b0);
                    tick(1'b1);
                end
            end
            check("rnd_end_halted", halted, ref_halt);
            check("rnd_end_pc", pc_o, ref_pc);
            check("rnd_end_ac", ac_o, ref_ac);
            diff = 0;
            foreach (mem[i]) if (mem[i] !== ref_mem[i]) diff++;
            check("rnd_mem_diff", diff, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
